// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the general-purpose register file.
package regfile_pkg;

    localparam int unsigned RWIDTH   = 6;
    localparam int unsigned DWIDTH   = 32;
    localparam int unsigned ZERO_REG = 0;

    typedef logic [RWIDTH-1:0] reg_addr_t;
    typedef logic [DWIDTH-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// Combinational read mux for one register-file port; register 0 always reads zero.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned RWIDTH = regfile_pkg::RWIDTH,
    parameter int unsigned DWIDTH = regfile_pkg::DWIDTH
) (
    input  logic [DWIDTH-1:0] regs_i [2**RWIDTH],
    input  logic [RWIDTH-1:0] addr_i,
    output logic [DWIDTH-1:0] data_o
);

    // Masking here keeps register 0 at zero even before the first reset.
    always_comb begin
        data_o = '0;
        if (addr_i != RWIDTH'(ZERO_REG)) begin
            data_o = regs_i[addr_i];
        end
    end

endmodule : regfile_rdport

// File: rtl/regfile_32bit.sv
// Register file: 2**RWIDTH words, two asynchronous read ports, one clocked write port.
module regfile_32bit
    import regfile_pkg::*;
#(
    parameter int unsigned RWIDTH = regfile_pkg::RWIDTH,
    parameter int unsigned DWIDTH = regfile_pkg::DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RWIDTH-1:0] ra1,
    input  logic [RWIDTH-1:0] ra2,
    input  logic [RWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] wd,
    input  logic              we,
    output logic [DWIDTH-1:0] rd1,
    output logic [DWIDTH-1:0] rd2
);

    localparam int unsigned NREGS = 2**RWIDTH;

    typedef logic [DWIDTH-1:0] word_t;

    word_t mem_q [NREGS];
    logic  wr_en_c;

    assign wr_en_c = we && (wa != RWIDTH'(ZERO_REG));

    // Synchronous clear takes priority over a coincident write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem_q[wa] <= wd;
        end
    end

    regfile_rdport #(
        .RWIDTH (RWIDTH),
        .DWIDTH (DWIDTH)
    ) u_rdport1 (
        .regs_i (mem_q),
        .addr_i (ra1),
        .data_o (rd1)
    );

    regfile_rdport #(
        .RWIDTH (RWIDTH),
        .DWIDTH (DWIDTH)
    ) u_rdport2 (
        .regs_i (mem_q),
        .addr_i (ra2),
        .data_o (rd2)
    );

endmodule : regfile_32bit

// File: tb/tb_regfile_32bit.sv
// Self-checking bench for regfile_32bit: directed vector table, hand sequences, random vs. array model.
module tb_regfile_32bit;

    logic        clk;
    logic        rst_n;
    logic [5:0]  ra1, ra2, wa;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd1, rd2;

    int checks = 0;
    int errors = 0;

    regfile_32bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa    (wa),
        .wd    (wd),
        .we    (we),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [5:0]  ra1;
        logic [5:0]  ra2;
        logic        chk_pre;
        logic [31:0] pre1;
        logic [31:0] pre2;
        logic [31:0] post1;
        logic [31:0] post2;
    } vec_t;

    vec_t vecs [12];

    logic [31:0] mdl [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [5:0] a);
        return (a == 6'd0) ? 32'h0 : mdl[a];
    endfunction

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 6'd0,  6'd41, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b0, 6'd0,  32'h0,        6'd35, 6'd0,  1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b1, 1'b1, 6'd63, 32'hFFAAFFAA, 6'd63, 6'd0,  1'b1, 32'h0,        32'h0,        32'hFFAAFFAA, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 6'd12, 32'hAAAAAAAA, 6'd11, 6'd63, 1'b1, 32'h0,        32'hFFAAFFAA, 32'h0,        32'hFFAAFFAA};
        vecs[4]  = '{1'b1, 1'b0, 6'd0,  32'h0,        6'd12, 6'd63, 1'b1, 32'hAAAAAAAA, 32'hFFAAFFAA, 32'hAAAAAAAA, 32'hFFAAFFAA};
        vecs[5]  = '{1'b1, 1'b0, 6'd0,  32'h0,        6'd21, 6'd56, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[6]  = '{1'b1, 1'b0, 6'd12, 32'h12121212, 6'd12, 6'd63, 1'b1, 32'hAAAAAAAA, 32'hFFAAFFAA, 32'hAAAAAAAA, 32'hFFAAFFAA};
        vecs[7]  = '{1'b1, 1'b1, 6'd0,  32'hBBBBBBBB, 6'd0,  6'd0,  1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[8]  = '{1'b1, 1'b0, 6'd0,  32'h0,        6'd63, 6'd63, 1'b1, 32'hFFAAFFAA, 32'hFFAAFFAA, 32'hFFAAFFAA, 32'hFFAAFFAA};
        vecs[9]  = '{1'b1, 1'b1, 6'd5,  32'h12345678, 6'd5,  6'd12, 1'b1, 32'h0,        32'hAAAAAAAA, 32'h12345678, 32'hAAAAAAAA};
        vecs[10] = '{1'b0, 1'b1, 6'd5,  32'hCAFEF00D, 6'd5,  6'd63, 1'b1, 32'h12345678, 32'hFFAAFFAA, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b1, 6'd5,  32'h0F0F0F0F, 6'd5,  6'd12, 1'b1, 32'h0,        32'h0,        32'h0F0F0F0F, 32'h0};

        rst_n = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

        // Register 0 reads zero even before any reset.
        #1;
        check("pre_reset_r0_rd1", rd1, 32'h0);
        check("pre_reset_r0_rd2", rd2, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            #1;
            if (vecs[i].chk_pre) begin
                check($sformatf("vec%0d_pre_rd1", i), rd1, vecs[i].pre1);
                check($sformatf("vec%0d_pre_rd2", i), rd2, vecs[i].pre2);
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_post_rd1", i), rd1, vecs[i].post1);
            check($sformatf("vec%0d_post_rd2", i), rd2, vecs[i].post2);
        end

        // Dual-port same address, then a combinational switch of ra2 with no edge.
        @(negedge clk);
        rst_n = 1'b1; we = 1'b1; wa = 6'd63; wd = 32'hFFAAFFAA;
        @(negedge clk);
        wa = 6'd12; wd = 32'hAAAAAAAA;
        @(negedge clk);
        we = 1'b0; ra1 = 6'd63; ra2 = 6'd63;
        #1;
        check("same_addr_rd1", rd1, 32'hFFAAFFAA);
        check("same_addr_rd2", rd2, 32'hFFAAFFAA);
        ra2 = 6'd12;
        #1;
        check("midcycle_ra2_switch", rd2, 32'hAAAAAAAA);
        check("midcycle_rd1_stable", rd1, 32'hFFAAFFAA);

        // A write-enable pulse that is gone by the edge must not write.
        @(negedge clk);
        ra1 = 6'd7;
        #1; we = 1'b1; wa = 6'd7; wd = 32'h77777777;
        #2; we = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_we_no_write", rd1, 32'h0);

        // Randomized traffic against an array model, starting from a clean reset.
        @(negedge clk);
        rst_n = 1'b0; we = 1'b0;
        @(posedge clk);
        for (int r = 0; r < 64; r++) mdl[r] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 39) != 0);
            we    = $urandom_range(0, 3) != 0;
            wa    = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            wd    = $urandom;
            ra1   = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
            ra2   = ($urandom_range(0, 7) == 0) ? ra1 : 6'($urandom_range(0, 63));
            #1;
            check("rand_pre_rd1", rd1, mdl_read(ra1));
            check("rand_pre_rd2", rd2, mdl_read(ra2));
            @(posedge clk);
            if (!rst_n) begin
                for (int r = 0; r < 64; r++) mdl[r] = 32'h0;
            end else if (we) begin
                mdl[wa] = wd;
            end
            #1;
            check("rand_post_rd1", rd1, mdl_read(ra1));
            check("rand_post_rd2", rd2, mdl_read(ra2));
        end

        // Sweep every address on both ports against the model.
        @(negedge clk);
        rst_n = 1'b1; we = 1'b0;
        for (int a = 0; a < 64; a++) begin
            ra1 = 6'(a);
            ra2 = 6'(63 - a);
            #1;
            check("sweep_rd1", rd1, mdl_read(ra1));
            check("sweep_rd2", rd2, mdl_read(ra2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_32bit
